// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the LSU-to-memory interface.
// Accepts one request at a time, waits LATENCY cycles, accesses a
// word-organised array under a byte-lane mask, then holds the response
// until the requester takes it.
//
// Optional build macro: DMEM_RESP_MISALIGN_CHK_EN
//   When defined, misaligned or unsupported mask/address combinations are
//   rejected with rsp_err_o=1 and no array write.
//
// state  | meaning
// IDLE   | ready for a request; latches addr/wdata/mask on accept
// WAIT   | wait counter running down toward the access
// ACCESS | single cycle: array write or read, response registered
// RESP   | response held until rsp_valid_o & rsp_ready_i
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wr_mask_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  mask_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IW-1:0] mem_idx;
  logic          in_range;
  logic          misalign;
  logic          acc_err;
  logic          acc_wr;
  logic [31:0]   acc_rdata;

  assign mem_idx  = addr_q[IW+1:2];
  assign in_range = ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));

`ifdef DMEM_RESP_MISALIGN_CHK_EN
  // Reject mask/offset pairs that do not describe a naturally aligned access.
  always_comb begin
    misalign = 1'b0;
    case (mask_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: misalign = 1'b0;
      4'b0011, 4'b1100:                            misalign = addr_q[0];
      4'b1111:                                     misalign = (addr_q[1:0] != 2'b00);
      default:                                     misalign = 1'b1;
    endcase
  end
`else
  // Byte offset is meaningless without the alignment check.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_q[1:0];
  assign misalign = 1'b0;
`endif

  // Access decision for the ACCESS cycle: error, masked write, or read.
  always_comb begin
    acc_err   = !in_range || misalign;
    acc_wr    = !acc_err && (mask_q != 4'b0000);
    acc_rdata = 32'h0;
    if (!acc_err && (mask_q == 4'b0000)) begin
      acc_rdata = mem[mem_idx];
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept  = 1'b1;
          cnt_d   = LAT4;
          state_d = (LATENCY > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, request latch and response registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      mask_q  <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        mask_q  <= req_wr_mask_i;
      end
      if (state_q == ST_ACCESS) begin
        rdata_q <= acc_rdata;
        err_q   <= acc_err;
      end
    end
  end

  // Array write; reset at the ACCESS edge suppresses it. Contents are never cleared.
  always_ff @(posedge clk) begin
    if (reset_n && (state_q == ST_ACCESS) && acc_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (mask_q[k]) begin
          mem[mem_idx][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with default parameters
// (DEPTH_WORDS=1024, LATENCY=2).
module tb_dmem_responder;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  dmem_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_wr_mask_i(req_mask),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction from IDLE with rsp_ready held high. lat counts edges
  // after the accept edge until rsp_valid is first seen (#1 after an edge);
  // with LATENCY=2 it is seen after edge N+3, so the handshake is edge N+4.
  task automatic transact(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                          output logic [31:0] rd, output logic er, output int lat);
    rsp_ready = 1'b1;
    req_addr  = a;
    req_wdata = wd;
    req_mask  = m;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 32'hffff_fffc;
    req_wdata = 32'hdead_dead;
    req_mask  = 4'b1111;
    check("busy_after_accept", {31'b0, req_ready}, 32'd0);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
    check("idle_after_rsp", {31'b0, req_ready}, 32'd1);
    check("valid_drop_after_rsp", {31'b0, rsp_valid}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_mask  = 4'h0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err",   {31'b0, rsp_err}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Word write then read
    transact(32'h0, 32'habcdef89, 4'b1111, rd, er, lat);
    check("wr0_lat",   lat, 32'd3);
    check("wr0_rdata", rd, 32'h0);
    check("wr0_err",   {31'b0, er}, 32'd0);
    transact(32'h0, 32'h0, 4'b0000, rd, er, lat);
    check("rd0_lat",   lat, 32'd3);
    check("rd0_rdata", rd, 32'habcdef89);
    check("rd0_err",   {31'b0, er}, 32'd0);

    // Byte lanes
    transact(32'h4, 32'ha1c2e394, 4'b1111, rd, er, lat);
    transact(32'h4, 32'h41414141, 4'b0010, rd, er, lat);
    check("lane1_err", {31'b0, er}, 32'd0);
    transact(32'h4, 32'h93419341, 4'b1100, rd, er, lat);
    check("lane32_err", {31'b0, er}, 32'd0);
    transact(32'h4, 32'h0, 4'b0000, rd, er, lat);
    check("lanes_rdata", rd, 32'h93414194);

    // Backpressure: hold rsp_ready low for 5 RESP cycles
    rsp_ready = 1'b0;
    req_addr  = 32'h0;
    req_mask  = 4'b0000;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", lat, 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rdata", rsp_rdata, 32'habcdef89);
      check("bp_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle", {31'b0, req_ready}, 32'd1);
    check("bp_valid_drop", {31'b0, rsp_valid}, 32'd0);

    // Out of range: last word legal, DEPTH_WORDS rejected
    transact(32'hffc, 32'h5a5a5a5a, 4'b1111, rd, er, lat);
    check("last_wr_err", {31'b0, er}, 32'd0);
    transact(32'h1000, 32'h0, 4'b0000, rd, er, lat);
    check("oor_rd_err",   {31'b0, er}, 32'd1);
    check("oor_rd_rdata", rd, 32'h0);
    transact(32'h1000, 32'hffffffff, 4'b1111, rd, er, lat);
    check("oor_wr_err", {31'b0, er}, 32'd1);
    transact(32'hffc, 32'h0, 4'b0000, rd, er, lat);
    check("last_rd_rdata", rd, 32'h5a5a5a5a);
    check("last_rd_err",   {31'b0, er}, 32'd0);
    transact(32'h0, 32'h0, 4'b0000, rd, er, lat);
    check("oor_no_wrap", rd, 32'habcdef89);

    // Reset during WAIT drops the pending write
    transact(32'h8, 32'h0badf00d, 4'b1111, rd, er, lat);
    req_addr  = 32'h8;
    req_wdata = 32'h12345678;
    req_mask  = 4'b1111;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("rw_ready", {31'b0, req_ready}, 32'd1);
    check("rw_valid", {31'b0, rsp_valid}, 32'd0);
    transact(32'h8, 32'h0, 4'b0000, rd, er, lat);
    check("rw_rdata", rd, 32'h0badf00d);

    // Reset at the ACCESS edge suppresses the write
    req_addr  = 32'h8;
    req_wdata = 32'hdeadbeef;
    req_mask  = 4'b1111;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("ra_valid", {31'b0, rsp_valid}, 32'd0);
    transact(32'h8, 32'h0, 4'b0000, rd, er, lat);
    check("ra_rdata", rd, 32'h0badf00d);

    // Misaligned word write
`ifdef DMEM_RESP_MISALIGN_CHK_EN
    transact(32'h9, 32'h11223344, 4'b1111, rd, er, lat);
    check("mis_err", {31'b0, er}, 32'd1);
    transact(32'h8, 32'h0, 4'b0000, rd, er, lat);
    check("mis_nowr", rd, 32'h0badf00d);
`else
    transact(32'h9, 32'h11223344, 4'b1111, rd, er, lat);
    check("mis_err", {31'b0, er}, 32'd0);
    transact(32'h8, 32'h0, 4'b0000, rd, er, lat);
    check("mis_wr", rd, 32'h11223344);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
